// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Sequences MEM-stage loads and stores onto an external 16-bit asynchronous
// SRAM. Each 32-bit word becomes two half-accesses, low half then high half,
// and each half is held on the pins for PHASE_CYCLES clocks. While an access
// is in flight `ready` is low so the pipeline freezes. `ready` rises for the
// single DONE cycle, and the MEM stage advances on that edge.
//
// Ports:
//   clk, rst        system clock and synchronous active-high reset
//   wr_en, rd_en    store / load request from the MEM stage (stores win)
//   address         CPU byte address (word aligned)
//   write_data      store data
//   read_data       registered load result, feeds the MEM/WB register
//   ready           0 = stall pipeline, 1 = MEM stage may advance
//   SRAM_*          board SRAM pins (CE_N/UB_N/LB_N permanently enabled)
// -----------------------------------------------------------------------------
module sram_controller #(
   parameter int BIT_NUMBER   = 32,
   parameter int PHASE_CYCLES = 3,
   parameter int MEM_BASE     = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [BIT_NUMBER-1:0] address,
   input  logic [BIT_NUMBER-1:0] write_data,
   output logic [BIT_NUMBER-1:0] read_data,
   output logic                  ready,
   inout  wire  [15:0]           SRAM_DQ,
   output logic [17:0]           SRAM_ADDR,
   output logic                  SRAM_WE_N,
   output logic                  SRAM_OE_N,
   output logic                  SRAM_CE_N,
   output logic                  SRAM_UB_N,
   output logic                  SRAM_LB_N
);

   localparam int CW = $clog2(PHASE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          is_write;   // latched operation, writes win over reads
   logic [16:0]   word;       // latched SRAM word index
   logic [15:0]   wdata_hi;   // upper store half, needed in HIGH
   logic [15:0]   dq_out;
   logic          dq_oe;
   logic [16:0]   word_next;

   // Word index relative to MEM_BASE; addresses beyond 2^17 words wrap.
   assign word_next = 17'((address - BIT_NUMBER'(MEM_BASE)) >> 2);

   // Combinational so the stall is seen in the same cycle as the request.
   assign ready = ~((wr_en | rd_en) & (state != DONE));

   assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

   // Pin outputs are registered: each is loaded on the edge that enters the
   // phase it belongs to, so the pins are glitch-free for the whole phase.
   // NOTE: non-blocking assignments throughout, so every right-hand side sees
   // the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         read_data <= '0;
         SRAM_ADDR <= '0;
         SRAM_WE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         dq_oe     <= 1'b0;
         // NOTE: the datapath latches are reset too; it is cheap at this size
         // and keeps simulation free of X on the bus after reset.
         dq_out    <= '0;
         is_write  <= 1'b0;
         word      <= '0;
         wdata_hi  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en | rd_en) begin
                  is_write  <= wr_en;
                  word      <= word_next;
                  wdata_hi  <= write_data[31:16];
                  count     <= '0;
                  state     <= LOW;
                  SRAM_ADDR <= {word_next, 1'b0};
                  SRAM_WE_N <= ~wr_en;
                  SRAM_OE_N <= wr_en;
                  dq_oe     <= wr_en;
                  dq_out    <= write_data[15:0];
               end
            end
            LOW: begin
               if (count == LAST) begin
                  count <= '0;
                  state <= HIGH;
                  if (!is_write) read_data[15:0] <= SRAM_DQ;
                  SRAM_ADDR <= {word, 1'b1};
                  dq_out    <= wdata_hi;
               end else begin
                  count <= count + CW'(1);
               end
            end
            HIGH: begin
               if (count == LAST) begin
                  count <= '0;
                  state <= DONE;
                  if (!is_write) read_data[31:16] <= SRAM_DQ;
                  SRAM_ADDR <= '0;
                  SRAM_WE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  dq_oe     <= 1'b0;
               end else begin
                  count <= count + CW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Directed bench for sram_controller. A small behavioural SRAM sits on the
// bus of the default instance (PHASE_CYCLES=3); a second instance with
// PHASE_CYCLES=1 checks the shortest phase length. Inputs change and outputs
// are sampled 1 ns after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sram_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [31:0] address = '0, write_data = '0;
   wire  [31:0] read_data;
   wire         ready;
   wire  [15:0] sram_dq;
   wire  [17:0] sram_addr;
   wire         sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

   logic        wr_en1 = 1'b0, rd_en1 = 1'b0;
   logic [31:0] address1 = '0, write_data1 = '0;
   wire  [31:0] read_data1;
   wire         ready1;
   wire  [15:0] dq1;
   wire  [17:0] addr1;
   wire         we1_n, oe1_n, ce1_n, ub1_n, lb1_n;

   int n_cmp = 0;
   int n_bad = 0;

   sram_controller dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
      .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n),
      .SRAM_LB_N(sram_lb_n)
   );

   sram_controller #(.PHASE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
      .write_data(write_data1), .read_data(read_data1), .ready(ready1),
      .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we1_n),
      .SRAM_OE_N(oe1_n), .SRAM_CE_N(ce1_n), .SRAM_UB_N(ub1_n),
      .SRAM_LB_N(lb1_n)
   );

   // Behavioural SRAM. When `probe` is set the bench drives a known pattern
   // onto an otherwise idle bus; it reads back intact only if the controller
   // has released DQ.
   logic [15:0] mem [0:262143];
   logic        probe = 1'b0;
   logic        pl_en = 1'b0;
   logic [17:0] pl_addr = '0;
   logic [15:0] pl_data = '0;
   int          we_strobes = 0;

   assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr]
                  : (probe ? 16'hA5C3 : 16'hzzzz);

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (!sram_we_n) mem[sram_addr] <= sram_dq;
      if (!sram_we_n) we_strobes <= we_strobes + 1;
   end

   task automatic preload(input logic [17:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      #1;
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", ready); end
   endtask

   // One 8-cycle access with the request held through DONE (cycles 0..7:
   // IDLE, LOW x3, HIGH x3, DONE). Expected pin values per cycle come from
   // the phase table; `word` is the hand-computed SRAM word index.
   task automatic run_access(input string tag, input logic wr, input logic rd,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [16:0] word, input logic [31:0] exp_rd);
      logic active, hi, exp_rdy, exp_we, exp_oe;
      logic [17:0] exp_addr;
      logic [15:0] exp_dq;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            wr_en = wr; rd_en = rd; address = addr; write_data = data;
         end
         #1;
         active   = (i >= 1) && (i <= 6);
         hi       = (i >= 4);
         exp_rdy  = (i == 7);
         exp_addr = active ? {word, hi} : 18'd0;
         exp_we   = !(active && wr);
         exp_oe   = !(active && !wr);
         exp_dq   = hi ? data[31:16] : data[15:0];
         n_cmp++; if (ready !== exp_rdy) begin n_bad++; $display("FAIL %s ready c%0d: got %b want %b", tag, i, ready, exp_rdy); end
         n_cmp++; if (sram_addr !== exp_addr) begin n_bad++; $display("FAIL %s addr c%0d: got %h want %h", tag, i, sram_addr, exp_addr); end
         n_cmp++; if (sram_we_n !== exp_we) begin n_bad++; $display("FAIL %s we_n c%0d: got %b want %b", tag, i, sram_we_n, exp_we); end
         n_cmp++; if (sram_oe_n !== exp_oe) begin n_bad++; $display("FAIL %s oe_n c%0d: got %b want %b", tag, i, sram_oe_n, exp_oe); end
         if (active && wr) begin
            n_cmp++; if (sram_dq !== exp_dq) begin n_bad++; $display("FAIL %s dq c%0d: got %h want %h", tag, i, sram_dq, exp_dq); end
         end
         if (i == 7) begin
            n_cmp++; if (read_data !== exp_rd) begin n_bad++; $display("FAIL %s read_data: got %h want %h", tag, read_data, exp_rd); end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready); end
      n_cmp++; if ({sram_we_n, sram_oe_n} !== 2'b11) begin n_bad++; $display("FAIL rst_we_oe: got %b want 11", {sram_we_n, sram_oe_n}); end
      n_cmp++; if (sram_addr !== 18'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
      n_cmp++; if (read_data !== 32'd0) begin n_bad++; $display("FAIL rst_read_data: got %h want 0", read_data); end
      n_cmp++; if ({sram_ce_n, sram_ub_n, sram_lb_n} !== 3'b000) begin n_bad++; $display("FAIL rst_ties: got %b want 000", {sram_ce_n, sram_ub_n, sram_lb_n}); end
      n_cmp++; if ({ready1, we1_n, oe1_n} !== 3'b111) begin n_bad++; $display("FAIL rst_dut1: got %b want 111", {ready1, we1_n, oe1_n}); end
      rst = 1'b0;
   endtask

   task automatic test_idle();
      probe = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready c%0d: got %b want 1", i, ready); end
         n_cmp++; if ({sram_we_n, sram_oe_n} !== 2'b11) begin n_bad++; $display("FAIL idle_we_oe c%0d: got %b want 11", i, {sram_we_n, sram_oe_n}); end
         n_cmp++; if (sram_dq !== 16'hA5C3) begin n_bad++; $display("FAIL idle_dq_released c%0d: got %h want a5c3", i, sram_dq); end
      end
      probe = 1'b0;
   endtask

   task automatic test_store();
      run_access("store", 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 17'd2, 32'd0);
      idle_cycle();
      n_cmp++; if (mem[4] !== 16'hBEEF) begin n_bad++; $display("FAIL store_mem4: got %h want beef", mem[4]); end
      n_cmp++; if (mem[5] !== 16'hDEAD) begin n_bad++; $display("FAIL store_mem5: got %h want dead", mem[5]); end
   endtask

   task automatic test_load();
      preload(18'd4, 16'h5678);
      preload(18'd5, 16'h1234);
      run_access("load", 1'b0, 1'b1, 32'd1032, 32'd0, 17'd2, 32'h12345678);
      idle_cycle();
      // Highest SRAM word: halves 0x3FFFE / 0x3FFFF.
      preload(18'h3FFFE, 16'hAAAA);
      preload(18'h3FFFF, 16'h5555);
      run_access("load_top", 1'b0, 1'b1, 32'd525308, 32'd0, 17'h1FFFF, 32'h5555AAAA);
      idle_cycle();
   endtask

   task automatic test_both();
      run_access("both", 1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 17'd3, 32'h5555AAAA);
      idle_cycle();
      run_access("both_readback", 1'b0, 1'b1, 32'd1036, 32'd0, 17'd3, 32'hCAFEF00D);
      idle_cycle();
   endtask

   task automatic test_wrap();
      // 2^17 words past MEM_BASE wraps back to SRAM word 0.
      run_access("wrap", 1'b1, 1'b0, 32'd525312, 32'h0BAD0F00, 17'd0, 32'hCAFEF00D);
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      run_access("b2b_load", 1'b0, 1'b1, 32'd1032, 32'd0, 17'd2, 32'h12345678);
      run_access("b2b_store", 1'b1, 1'b0, 32'd1040, 32'hA5A55A5A, 17'd4, 32'h12345678);
      idle_cycle();
   endtask

   task automatic test_reset_mid();
      int strobes_at_reset;
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1032; write_data = 32'h11112222;
      repeat (2) @(negedge clk);
      rst = 1'b1; wr_en = 1'b0; probe = 1'b1;
      @(negedge clk);
      #1;
      strobes_at_reset = we_strobes;
      n_cmp++; if ({sram_we_n, sram_oe_n} !== 2'b11) begin n_bad++; $display("FAIL midrst_we_oe: got %b want 11", {sram_we_n, sram_oe_n}); end
      n_cmp++; if (sram_addr !== 18'd0) begin n_bad++; $display("FAIL midrst_addr: got %h want 0", sram_addr); end
      n_cmp++; if (read_data !== 32'd0) begin n_bad++; $display("FAIL midrst_read_data: got %h want 0", read_data); end
      n_cmp++; if (sram_dq !== 16'hA5C3) begin n_bad++; $display("FAIL midrst_dq_released: got %h want a5c3", sram_dq); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", ready); end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      probe = 1'b0;
      n_cmp++; if (we_strobes !== strobes_at_reset) begin n_bad++; $display("FAIL midrst_strobes: got %0d want %0d", we_strobes, strobes_at_reset); end
      // A fresh access must start from IDLE with the full 7/1 ready pattern.
      run_access("post_rst", 1'b1, 1'b0, 32'd1032, 32'h0F0F0F0F, 17'd2, 32'd0);
      idle_cycle();
   endtask

   task automatic test_phase1();
      logic active, hi, exp_rdy;
      logic [17:0] exp_addr;
      logic [15:0] exp_dq;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            wr_en1 = 1'b1; address1 = 32'd1032; write_data1 = 32'hDEADBEEF;
         end
         #1;
         active   = (i == 1) || (i == 2);
         hi       = (i == 2);
         exp_rdy  = (i == 3);
         exp_addr = active ? {17'd2, hi} : 18'd0;
         exp_dq   = hi ? 16'hDEAD : 16'hBEEF;
         n_cmp++; if (ready1 !== exp_rdy) begin n_bad++; $display("FAIL p1_ready c%0d: got %b want %b", i, ready1, exp_rdy); end
         n_cmp++; if (addr1 !== exp_addr) begin n_bad++; $display("FAIL p1_addr c%0d: got %h want %h", i, addr1, exp_addr); end
         n_cmp++; if (we1_n !== !active) begin n_bad++; $display("FAIL p1_we_n c%0d: got %b want %b", i, we1_n, !active); end
         if (active) begin
            n_cmp++; if (dq1 !== exp_dq) begin n_bad++; $display("FAIL p1_dq c%0d: got %h want %h", i, dq1, exp_dq); end
         end
      end
      @(negedge clk);
      wr_en1 = 1'b0;
      #1;
      n_cmp++; if ({ready1, we1_n} !== 2'b11) begin n_bad++; $display("FAIL p1_end: got %b want 11", {ready1, we1_n}); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idle();
      test_store();
      test_load();
      test_both();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_phase1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
